// File: rtl/fmap_bank_ctrl.sv
// Feature-map bank responder: layer read/write ports with a fixed 2-cycle read
// latency, plus a host LOAD/DUMP streaming port used while no layer owns the bank.
module fmap_bank_ctrl #(
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 32768,
   parameter int DUMP_FIFO = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              layer_busy,
   input  logic [ADDR_W-1:0] fbank_raddr,
   input  logic              fbank_ren,
   output logic [DATA_W-1:0] fdata_r,
   input  logic [ADDR_W-1:0] fbank_waddr,
   input  logic [DATA_W-1:0] fdata_w,
   input  logic              fbank_wen,
   input  logic              host_cmd_valid,
   output logic              host_cmd_ready,
   input  logic              host_cmd_op,
   input  logic [ADDR_W-1:0] host_cmd_addr,
   input  logic [ADDR_W:0]   host_cmd_len,
   input  logic              host_wr_valid,
   output logic              host_wr_ready,
   input  logic [DATA_W-1:0] host_wr_data,
   output logic              host_rd_valid,
   input  logic              host_rd_ready,
   output logic [DATA_W-1:0] host_rd_data,
   output logic              host_done,
   output logic              err_conflict
);

   localparam int FW = $clog2(DUMP_FIFO);
   localparam int CW = FW + 1;
   localparam int LW = ADDR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DUMP,
      ST_DONE
   } state_t;

   state_t            r_state;
   logic              r_alive;
   logic [ADDR_W-1:0] r_ptr;
   logic [LW-1:0]     r_remaining;
   logic [LW-1:0]     r_pop_left;
   logic              r_s1_layer;
   logic              r_s1_dump;
   logic [DATA_W-1:0] r_ram_q;
   logic [DATA_W-1:0] r_fdata;
   logic              r_err;
   logic [DATA_W-1:0] r_mem  [DEPTH];
   logic [DATA_W-1:0] r_fifo [DUMP_FIFO];
   logic [FW-1:0]     r_fifo_wr;
   logic [FW-1:0]     r_fifo_rd;
   logic [CW-1:0]     r_fifo_cnt;

   logic              w_idle;
   logic              w_cmd_ready;
   logic              w_cmd_fire;
   logic              w_wr_fire;
   logic              w_rd_valid;
   logic              w_pop;
   logic [CW:0]       w_occupancy;
   logic              w_dump_issue;
   logic              w_layer_rd;
   logic              w_layer_wr;
   logic              w_conflict;
   logic              w_ram_re;
   logic [ADDR_W-1:0] w_ram_raddr;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_waddr;
   logic [DATA_W-1:0] w_ram_wdata;
   logic [ADDR_W-1:0] w_ptr_next;

   assign w_idle      = (r_state == ST_IDLE);
   // r_alive keeps the command port closed while rstn is held low.
   assign w_cmd_ready = r_alive & w_idle & ~layer_busy;
   assign w_cmd_fire  = host_cmd_valid & w_cmd_ready;
   assign w_wr_fire   = host_wr_valid & (r_state == ST_LOAD);
   assign w_rd_valid  = (r_fifo_cnt != '0);
   assign w_pop       = w_rd_valid & host_rd_ready;

   // Reads in flight are counted against FIFO space so a stalled host never overflows it.
   assign w_occupancy  = {1'b0, r_fifo_cnt} + {{CW{1'b0}}, r_s1_dump};
   assign w_dump_issue = (r_state == ST_DUMP) & (r_remaining != '0) &
                         (w_occupancy < (CW+1)'(DUMP_FIFO));

   assign w_layer_rd = w_idle & fbank_ren;
   assign w_layer_wr = w_idle & fbank_wen;
   assign w_conflict = ~w_idle & (fbank_ren | fbank_wen);

   assign w_ram_re    = w_layer_rd | w_dump_issue;
   assign w_ram_raddr = w_dump_issue ? r_ptr : fbank_raddr;
   assign w_ram_we    = rstn & (w_layer_wr | w_wr_fire);
   assign w_ram_waddr = w_wr_fire ? r_ptr : fbank_waddr;
   assign w_ram_wdata = w_wr_fire ? host_wr_data : fdata_w;

   assign w_ptr_next = (r_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_ptr + ADDR_W'(1);

   assign fdata_r        = r_fdata;
   assign host_cmd_ready = w_cmd_ready;
   assign host_wr_ready  = (r_state == ST_LOAD);
   assign host_rd_valid  = w_rd_valid;
   assign host_rd_data   = w_rd_valid ? r_fifo[r_fifo_rd] : '0;
   assign host_done      = (r_state == ST_DONE);
   assign err_conflict   = r_err;

   // NOTE: RAM and FIFO storage carry no reset so they map onto memory macros; contents survive rstn.
   always_ff @(posedge clk) begin
      if (w_ram_we) r_mem[w_ram_waddr] <= w_ram_wdata;
      if (w_ram_re) r_ram_q <= r_mem[w_ram_raddr];
      if (r_s1_dump) r_fifo[r_fifo_wr] <= r_ram_q;
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_alive     <= 1'b0;
         r_ptr       <= '0;
         r_remaining <= '0;
         r_pop_left  <= '0;
         r_s1_layer  <= 1'b0;
         r_s1_dump   <= 1'b0;
         r_fdata     <= '0;
         r_err       <= 1'b0;
         r_fifo_wr   <= '0;
         r_fifo_rd   <= '0;
         r_fifo_cnt  <= '0;
      end else begin
         r_alive    <= 1'b1;
         r_s1_layer <= w_layer_rd;
         r_s1_dump  <= w_dump_issue;
         if (r_s1_layer) r_fdata <= r_ram_q;
         if (w_conflict) r_err <= 1'b1;

         if (r_s1_dump) r_fifo_wr <= r_fifo_wr + FW'(1);
         if (w_pop)     r_fifo_rd <= r_fifo_rd + FW'(1);
         case ({r_s1_dump, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase

         case (r_state)
            ST_IDLE: begin
               if (w_cmd_fire) begin
                  r_ptr       <= host_cmd_addr;
                  r_remaining <= host_cmd_len;
                  r_pop_left  <= host_cmd_len;
                  if (host_cmd_len == '0) r_state <= ST_DONE;
                  else if (host_cmd_op)   r_state <= ST_DUMP;
                  else                    r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_wr_fire) begin
                  r_ptr       <= w_ptr_next;
                  r_remaining <= r_remaining - LW'(1);
                  if (r_remaining == LW'(1)) r_state <= ST_DONE;
               end
            end
            ST_DUMP: begin
               if (w_dump_issue) begin
                  r_ptr       <= w_ptr_next;
                  r_remaining <= r_remaining - LW'(1);
               end
               if (w_pop) begin
                  r_pop_left <= r_pop_left - LW'(1);
                  if (r_pop_left == LW'(1)) r_state <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
